// File: rtl/sched_pkg.sv
// sched_pkg: shared unit codes, forward selects and lane-entry type for the dual-issue scheduler.
package sched_pkg;
    typedef enum logic [1:0] {UNIT_AU, UNIT_MUL, UNIT_LSU, UNIT_NONE} unit_e;

    localparam logic [2:0] SEL_REGFILE = 3'd0;
    localparam logic [2:0] SEL_AU1     = 3'd1;
    localparam logic [2:0] SEL_AU2     = 3'd2;
    localparam logic [2:0] SEL_MUL1    = 3'd3;
    localparam logic [2:0] SEL_MUL2    = 3'd4;
    localparam logic [2:0] SEL_LSU     = 3'd5;
    localparam logic [2:0] SEL_WB1     = 3'd6;
    localparam logic [2:0] SEL_WB2     = 3'd7;

    localparam int CNT_W   = 3;
    localparam int N_LANES = 7;
    localparam int L_AU1   = 0;
    localparam int L_AU2   = 1;
    localparam int L_MUL1  = 2;
    localparam int L_MUL2  = 3;
    localparam int L_LSU   = 4;
    localparam int L_WB1   = 5;
    localparam int L_WB2   = 6;

    typedef struct packed {
        logic             valid;
        logic [4:0]       rd;
        logic             is_load;
        logic [CNT_W-1:0] countdown;
    } lane_entry_t;

    // Non-writing instructions are stored with rd=0 so they occupy a lane but never match.
    function automatic lane_entry_t mk_entry(input logic [4:0] rd, input logic rw, input logic ld,
                                             input logic [CNT_W-1:0] cd);
        mk_entry = {1'b1, rw ? rd : 5'd0, ld, cd};
    endfunction
endpackage

// File: rtl/dual_issue_scheduler_fwd_select.sv
// fwd_select: picks the highest-priority in-flight lane producing a source register.
module fwd_select
    import sched_pkg::*;
(
    input  logic [4:0]                     i_idx,
    input  logic                           i_en,
    input  lane_entry_t [N_LANES-1:0]      i_lanes,
    output logic [2:0]                     o_sel,
    output logic                           o_not_ready
);
    // Scan lowest priority first so the last hit (AU1 side) wins.
    always_comb begin
        o_sel = SEL_REGFILE;
        o_not_ready = 1'b0;
        for (int k = N_LANES - 1; k >= 0; k--) begin
            if (i_en && i_idx != 5'd0 && i_lanes[k].valid && i_lanes[k].rd == i_idx) begin
                o_sel = 3'(k + 1);
                o_not_ready = (k == L_MUL1 || k == L_MUL2 || (k == L_LSU && i_lanes[k].is_load))
                              && i_lanes[k].countdown != '0;
            end
        end
    end
endmodule

// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler: tracks in-flight destinations per lane and decides slot issue,
// forwarding selects and fetch stall for the dual-slot decode stage.
module dual_issue_scheduler
    import sched_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int LSU_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s0_valid,
    input  logic       s1_valid,
    input  logic [4:0] s0_rs1,
    input  logic [4:0] s0_rs2,
    input  logic [4:0] s1_rs1,
    input  logic [4:0] s1_rs2,
    input  logic       s0_use_rs2,
    input  logic       s1_use_rs2,
    input  logic [4:0] s0_rd,
    input  logic [4:0] s1_rd,
    input  logic       s0_reg_write,
    input  logic       s1_reg_write,
    input  logic [1:0] s0_unit,
    input  logic [1:0] s1_unit,
    input  logic       s0_is_load,
    input  logic       s1_is_load,
    input  logic       kill_s1,
    output logic [2:0] hazard_select1_s0,
    output logic [2:0] hazard_select2_s0,
    output logic [2:0] hazard_select1_s1,
    output logic [2:0] hazard_select2_s1,
    output logic       issue0,
    output logic       issue1,
    output logic       stall
);
    localparam logic [CNT_W-1:0] MUL_CD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] LSU_CD = CNT_W'(LSU_LAT - 1);

    lane_entry_t [N_LANES-1:0] r_lane;
    lane_entry_t [N_LANES-1:0] w_lane_nx;
    logic [3:0][4:0] w_idx;
    logic [3:0][2:0] w_sel;
    logic [3:0]      w_en;
    logic [3:0]      w_nr;
    logic            w_mul1_free, w_mul2_free, w_lsu_free;
    logic            w_raw, w_waw, w_struct1, w_issue0, w_issue1;

    function automatic logic done(input lane_entry_t e);
        done = e.valid && e.countdown == '0;
    endfunction

    function automatic lane_entry_t step(input lane_entry_t e);
        step = (e.valid && e.countdown != '0) ? {e.valid, e.rd, e.is_load, e.countdown - 1'b1} : '0;
    endfunction

    assign w_idx = {s1_rs2, s1_rs1, s0_rs2, s0_rs1};
    assign w_en  = {s1_use_rs2, 1'b1, s0_use_rs2, 1'b1};

    genvar g;
    for (g = 0; g < 4; g++) begin : g_fwd
        fwd_select u_fwd (
            .i_idx       (w_idx[g]),
            .i_en        (w_en[g]),
            .i_lanes     (r_lane),
            .o_sel       (w_sel[g]),
            .o_not_ready (w_nr[g])
        );
    end

    assign w_mul1_free = !r_lane[L_MUL1].valid || r_lane[L_MUL1].countdown == '0;
    assign w_mul2_free = !r_lane[L_MUL2].valid || r_lane[L_MUL2].countdown == '0;
    assign w_lsu_free  = !r_lane[L_LSU].valid  || r_lane[L_LSU].countdown  == '0;

    assign w_issue0 = rst_n && s0_valid && !w_nr[0] && !w_nr[1] &&
                      (s0_unit == UNIT_MUL ? w_mul1_free : s0_unit == UNIT_LSU ? w_lsu_free : 1'b1);

    assign w_raw = s0_reg_write && s0_rd != 5'd0 &&
                   (s0_rd == s1_rs1 || (s1_use_rs2 && s0_rd == s1_rs2));
    assign w_waw = s0_reg_write && s1_reg_write && s0_rd != 5'd0 && s0_rd == s1_rd;
    assign w_struct1 = s1_unit == UNIT_MUL ? w_mul2_free :
                       s1_unit == UNIT_LSU ? (w_lsu_free && s0_unit != UNIT_LSU) : 1'b1;

    assign w_issue1 = w_issue0 && s1_valid && !kill_s1 && !w_nr[2] && !w_nr[3] &&
                      !w_raw && !w_waw && w_struct1;

    // Writeback collisions resolve toward the youngest producer; the older one is not tracked.
    always_comb begin
        w_lane_nx = '0;
        w_lane_nx[L_AU1] = (w_issue0 && s0_unit == UNIT_AU) ? mk_entry(s0_rd, s0_reg_write, 1'b0, '0) : '0;
        w_lane_nx[L_AU2] = (w_issue1 && s1_unit == UNIT_AU) ? mk_entry(s1_rd, s1_reg_write, 1'b0, '0) : '0;
        w_lane_nx[L_MUL1] = (w_issue0 && s0_unit == UNIT_MUL) ? mk_entry(s0_rd, s0_reg_write, 1'b0, MUL_CD)
                                                              : step(r_lane[L_MUL1]);
        w_lane_nx[L_MUL2] = (w_issue1 && s1_unit == UNIT_MUL) ? mk_entry(s1_rd, s1_reg_write, 1'b0, MUL_CD)
                                                              : step(r_lane[L_MUL2]);
        w_lane_nx[L_LSU] = (w_issue0 && s0_unit == UNIT_LSU) ? mk_entry(s0_rd, s0_reg_write, s0_is_load, LSU_CD) :
                           (w_issue1 && s1_unit == UNIT_LSU) ? mk_entry(s1_rd, s1_reg_write, s1_is_load, LSU_CD) :
                                                               step(r_lane[L_LSU]);
        w_lane_nx[L_WB1] = done(r_lane[L_AU1])  ? r_lane[L_AU1]  :
                           done(r_lane[L_MUL1]) ? r_lane[L_MUL1] :
                           done(r_lane[L_LSU])  ? r_lane[L_LSU]  : '0;
        w_lane_nx[L_WB2] = done(r_lane[L_AU2])  ? r_lane[L_AU2]  :
                           done(r_lane[L_MUL2]) ? r_lane[L_MUL2] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_lane <= '0;
        else        r_lane <= w_lane_nx;
    end

    assign issue0 = w_issue0;
    assign issue1 = w_issue1;
    assign stall  = rst_n && ((s0_valid && !w_issue0) || (s1_valid && !kill_s1 && !w_issue1));
    assign hazard_select1_s0 = rst_n ? w_sel[0] : SEL_REGFILE;
    assign hazard_select2_s0 = rst_n ? w_sel[1] : SEL_REGFILE;
    assign hazard_select1_s1 = rst_n ? w_sel[2] : SEL_REGFILE;
    assign hazard_select2_s1 = rst_n ? w_sel[3] : SEL_REGFILE;
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb_dual_issue_scheduler: scoreboard bench for issue, stall and forwarding selects.
module tb_dual_issue_scheduler;
    import sched_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s0_valid, s1_valid, s0_use_rs2, s1_use_rs2, s0_reg_write, s1_reg_write;
    logic       s0_is_load, s1_is_load, kill_s1;
    logic [4:0] s0_rs1, s0_rs2, s1_rs1, s1_rs2, s0_rd, s1_rd;
    logic [1:0] s0_unit, s1_unit;
    logic [2:0] hazard_select1_s0, hazard_select2_s0, hazard_select1_s1, hazard_select2_s1;
    logic       issue0, issue1, stall;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       i0, i1, st;
        logic [2:0] s10, s20, s11, s21;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    dual_issue_scheduler #(.MUL_LAT(3), .LSU_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s1_valid(s1_valid),
        .s0_rs1(s0_rs1), .s0_rs2(s0_rs2), .s1_rs1(s1_rs1), .s1_rs2(s1_rs2),
        .s0_use_rs2(s0_use_rs2), .s1_use_rs2(s1_use_rs2),
        .s0_rd(s0_rd), .s1_rd(s1_rd),
        .s0_reg_write(s0_reg_write), .s1_reg_write(s1_reg_write),
        .s0_unit(s0_unit), .s1_unit(s1_unit),
        .s0_is_load(s0_is_load), .s1_is_load(s1_is_load),
        .kill_s1(kill_s1),
        .hazard_select1_s0(hazard_select1_s0), .hazard_select2_s0(hazard_select2_s0),
        .hazard_select1_s1(hazard_select1_s1), .hazard_select2_s1(hazard_select2_s1),
        .issue0(issue0), .issue1(issue1), .stall(stall)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic s0_set(input logic v, input logic [1:0] u, input logic [4:0] rd, input logic rw,
                          input logic [4:0] a, input logic [4:0] b, input logic ub, input logic ld);
        s0_valid = v; s0_unit = u; s0_rd = rd; s0_reg_write = rw;
        s0_rs1 = a; s0_rs2 = b; s0_use_rs2 = ub; s0_is_load = ld;
    endtask

    task automatic s1_set(input logic v, input logic [1:0] u, input logic [4:0] rd, input logic rw,
                          input logic [4:0] a, input logic [4:0] b, input logic ub, input logic ld);
        s1_valid = v; s1_unit = u; s1_rd = rd; s1_reg_write = rw;
        s1_rs1 = a; s1_rs2 = b; s1_use_rs2 = ub; s1_is_load = ld;
    endtask

    task automatic idle;
        s0_set(0, UNIT_NONE, 0, 0, 0, 0, 0, 0);
        s1_set(0, UNIT_NONE, 0, 0, 0, 0, 0, 0);
        kill_s1 = 1'b0;
    endtask

    task automatic cyc(input string tag, input logic e0, input logic e1, input logic es,
                       input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] d);
        exp_t e;
        e.i0 = e0; e.i1 = e1; e.st = es; e.s10 = a; e.s20 = b; e.s11 = c; e.s21 = d;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check({tag, ".issue0"}, 8'(issue0), 8'(e.i0));
        check({tag, ".issue1"}, 8'(issue1), 8'(e.i1));
        check({tag, ".stall"},  8'(stall),  8'(e.st));
        check({tag, ".sel1_s0"}, 8'(hazard_select1_s0), 8'(e.s10));
        check({tag, ".sel2_s0"}, 8'(hazard_select2_s0), 8'(e.s20));
        check({tag, ".sel1_s1"}, 8'(hazard_select1_s1), 8'(e.s11));
        check({tag, ".sel2_s1"}, 8'(hazard_select2_s1), 8'(e.s21));
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        idle;
        repeat (4) cyc("drain", 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle;
        s0_set(1, UNIT_AU, 5, 1, 5, 6, 1, 0);
        s1_set(1, UNIT_AU, 6, 1, 5, 0, 0, 0);
        #1;
        cyc("rst0", 0, 0, 0, 0, 0, 0, 0);
        cyc("rst1", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        drain;

        s0_set(1, UNIT_AU, 5, 1, 0, 0, 0, 0); s1_set(1, UNIT_AU, 6, 1, 0, 0, 0, 0);
        cyc("dual_c0", 1, 1, 0, 0, 0, 0, 0);
        idle; s0_set(1, UNIT_NONE, 0, 0, 5, 6, 1, 0);
        cyc("dual_c1", 1, 0, 0, 1, 2, 0, 0);
        cyc("dual_c2", 1, 0, 0, 6, 7, 0, 0);
        drain;

        s0_set(1, UNIT_AU, 3, 1, 0, 0, 0, 0); s1_set(1, UNIT_AU, 10, 1, 3, 0, 0, 0);
        cyc("raw_c0", 1, 0, 1, 0, 0, 0, 0);
        idle; s0_set(1, UNIT_AU, 10, 1, 3, 0, 0, 0);
        cyc("raw_c1", 1, 0, 0, 1, 0, 0, 0);
        drain;

        s0_set(1, UNIT_MUL, 7, 1, 0, 0, 0, 0);
        cyc("mul_c0", 1, 0, 0, 0, 0, 0, 0);
        s0_set(1, UNIT_AU, 11, 1, 7, 0, 0, 0);
        cyc("mul_c1", 0, 0, 1, 3, 0, 0, 0);
        cyc("mul_c2", 0, 0, 1, 3, 0, 0, 0);
        cyc("mul_c3", 1, 0, 0, 3, 0, 0, 0);
        s0_set(1, UNIT_AU, 12, 1, 7, 0, 0, 0);
        cyc("mul_wb", 1, 0, 0, 6, 0, 0, 0);
        drain;

        s0_set(1, UNIT_LSU, 9, 1, 0, 0, 0, 1);
        cyc("ld_c0", 1, 0, 0, 0, 0, 0, 0);
        s0_set(1, UNIT_AU, 13, 1, 9, 0, 0, 0);
        cyc("ld_c1", 0, 0, 1, 5, 0, 0, 0);
        cyc("ld_c2", 1, 0, 0, 5, 0, 0, 0);
        drain;

        s0_set(1, UNIT_LSU, 9, 1, 0, 0, 0, 1);
        cyc("lsu_c0", 1, 0, 0, 0, 0, 0, 0);
        s0_set(1, UNIT_LSU, 2, 0, 0, 0, 0, 0);
        cyc("lsu_busy", 0, 0, 1, 0, 0, 0, 0);
        cyc("lsu_free", 1, 0, 0, 0, 0, 0, 0);
        drain;

        s0_set(1, UNIT_AU, 14, 1, 0, 0, 0, 0); s1_set(1, UNIT_AU, 15, 1, 0, 0, 0, 0); kill_s1 = 1'b1;
        cyc("kill", 1, 0, 0, 0, 0, 0, 0);
        idle; s0_set(1, UNIT_MUL, 7, 1, 0, 0, 0, 0);
        cyc("kst_c0", 1, 0, 0, 0, 0, 0, 0);
        s0_set(1, UNIT_MUL, 17, 1, 0, 0, 0, 0); s1_set(1, UNIT_AU, 18, 1, 0, 0, 0, 0); kill_s1 = 1'b1;
        cyc("kill_stall", 0, 0, 1, 0, 0, 0, 0);
        drain;

        s0_set(1, UNIT_AU, 0, 1, 0, 0, 0, 0);
        cyc("x0_c0", 1, 0, 0, 0, 0, 0, 0);
        s0_set(1, UNIT_AU, 16, 1, 0, 0, 1, 0);
        cyc("x0_c1", 1, 0, 0, 0, 0, 0, 0);
        s0_set(1, UNIT_AU, 8, 0, 0, 0, 0, 0);
        cyc("nowr_c0", 1, 0, 0, 0, 0, 0, 0);
        s0_set(1, UNIT_AU, 17, 1, 8, 8, 1, 0);
        cyc("nowr_c1", 1, 0, 0, 0, 0, 0, 0);
        drain;

        s0_set(1, UNIT_AU, 4, 1, 0, 0, 0, 0); s1_set(1, UNIT_AU, 4, 1, 0, 0, 0, 0);
        cyc("waw", 1, 0, 1, 0, 0, 0, 0);
        drain;

        s0_set(1, UNIT_LSU, 0, 0, 0, 0, 0, 0); s1_set(1, UNIT_LSU, 0, 0, 0, 0, 0, 0);
        cyc("lsu2", 1, 0, 1, 0, 0, 0, 0);
        drain;

        s0_set(1, UNIT_AU, 20, 1, 0, 0, 0, 0);
        cyc("s1f_c0", 1, 0, 0, 0, 0, 0, 0);
        s0_set(1, UNIT_NONE, 0, 0, 0, 0, 0, 0); s1_set(1, UNIT_MUL, 21, 1, 20, 20, 1, 0);
        cyc("s1f_c1", 1, 1, 0, 0, 0, 1, 1);
        s1_set(1, UNIT_MUL, 22, 1, 0, 0, 0, 0);
        cyc("mul2_busy", 1, 0, 1, 0, 0, 0, 0);
        s1_set(1, UNIT_AU, 23, 1, 21, 0, 0, 0);
        cyc("mul2_nr", 1, 0, 1, 0, 0, 4, 0);
        cyc("mul2_rdy", 1, 1, 0, 0, 0, 4, 0);
        s1_set(1, UNIT_AU, 24, 1, 21, 0, 0, 0);
        cyc("wb2", 1, 1, 0, 0, 0, 7, 0);
        drain;

        s0_set(1, UNIT_MUL, 7, 1, 0, 0, 0, 0);
        cyc("mr_c0", 1, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0; s0_set(1, UNIT_AU, 11, 1, 7, 0, 0, 0);
        cyc("mr_rst", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc("mr_c2", 1, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
